// File: rtl/pipeline_pkg.sv
// Shared definitions for the ID stage: opcodes, ALU function codes, widths and FSM encoding.
package pipeline_pkg;

   localparam int DATA_W_DEF  = 16;
   localparam int REG_CNT_DEF = 8;
   localparam int REG_AW_DEF  = 3;

   localparam logic [4:0] OP_NOP = 5'b00000;
   localparam logic [4:0] OP_NOT = 5'b00001;
   localparam logic [4:0] OP_ADD = 5'b00010;
   localparam logic [4:0] OP_STD = 5'b00011;
   localparam logic [4:0] OP_LDD = 5'b00100;
   localparam logic [4:0] OP_LDM = 5'b00101;

   localparam logic [3:0] FUNC_STD = 4'b0000;
   localparam logic [3:0] FUNC_NOT = 4'b0001;
   localparam logic [3:0] FUNC_ADD = 4'b0010;

   typedef enum logic {
      ST_OPC = 1'b0,
      ST_IMM = 1'b1
   } dec_state_t;

endpackage

// File: rtl/decode_stage_if.sv
// ID/EX bundle: decode drives it as master, the execute stage consumes it as slave.
interface decode_stage_if
   import pipeline_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
);
   logic              out_valid;
   logic              out_ready;
   logic              alu_en;
   logic [3:0]        func_ctrl;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [REG_AW-1:0] dest;
   logic              reg_we;
   logic              mem_rd;
   logic              mem_wr;
   logic              illegal;

   modport master (
      output out_valid, alu_en, func_ctrl, op_a, op_b, dest, reg_we, mem_rd, mem_wr, illegal,
      input  out_ready
   );

   modport slave (
      input  out_valid, alu_en, func_ctrl, op_a, op_b, dest, reg_we, mem_rd, mem_wr, illegal,
      output out_ready
   );
endinterface

// File: rtl/register_file.sv
// Two-read, one-write register file with synchronous reset and write-through bypass.
module register_file
   import pipeline_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_CNT = REG_CNT_DEF,
   parameter int REG_AW  = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [REG_AW-1:0] i_raddr_a,
   output logic [DATA_W-1:0] o_rdata_a,
   input  logic [REG_AW-1:0] i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_b
);
   logic [DATA_W-1:0] r_mem [REG_CNT];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_CNT; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Bypass lets an instruction decoded in the same cycle as its source's write-back see the new value.
   assign o_rdata_a = (i_we && (i_waddr == i_raddr_a)) ? i_wdata : r_mem[i_raddr_a];
   assign o_rdata_b = (i_we && (i_waddr == i_raddr_b)) ? i_wdata : r_mem[i_raddr_b];
endmodule

// File: rtl/decode_stage.sv
// ID stage: decodes IF/ID words, reads operands and registers the ID/EX bundle.
//
// state  | meaning
// ST_OPC | next accepted word is an opcode
// ST_IMM | next accepted word is the LDM immediate
module decode_stage
   import pipeline_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_CNT = REG_CNT_DEF,
   parameter int REG_AW  = REG_AW_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   instr,
   input  logic                wb_en,
   input  logic [REG_AW-1:0]   wb_addr,
   input  logic [DATA_W-1:0]   wb_data,
   decode_stage_if.master      ex
);
   dec_state_t        r_state, w_state_nxt;
   logic [REG_AW-1:0] r_ldm_rd;

   logic              r_out_valid, r_alu_en, r_reg_we, r_mem_rd, r_mem_wr, r_illegal;
   logic [3:0]        r_func_ctrl;
   logic [DATA_W-1:0] r_op_a, r_op_b;
   logic [REG_AW-1:0] r_dest;

   logic [4:0]        w_op;
   logic [REG_AW-1:0] w_rd, w_rs1, w_rs2, w_raddr_b;
   logic [DATA_W-1:0] w_rdata_a, w_rdata_b;
   logic              w_xfer, w_ldm_start, w_load;

   logic              w_alu_en, w_reg_we, w_mem_rd, w_mem_wr, w_illegal;
   logic [3:0]        w_func_ctrl;
   logic [DATA_W-1:0] w_op_a, w_op_b;
   logic [REG_AW-1:0] w_dest;

   assign w_op  = instr[15:11];
   assign w_rd  = instr[10:8];
   assign w_rs1 = instr[7:5];
   assign w_rs2 = instr[4:2];

   // STD reads rd as its store data, so port B switches from rs2 to rd.
   assign w_raddr_b = (w_op == OP_STD) ? w_rd : w_rs2;

   register_file #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .REG_AW(REG_AW)) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .i_we      (wb_en),
      .i_waddr   (wb_addr),
      .i_wdata   (wb_data),
      .i_raddr_a (w_rs1),
      .o_rdata_a (w_rdata_a),
      .i_raddr_b (w_raddr_b),
      .o_rdata_b (w_rdata_b)
   );

   assign in_ready    = !r_out_valid || ex.out_ready;
   assign w_xfer      = in_valid && in_ready;
   assign w_ldm_start = w_xfer && (r_state == ST_OPC) && (w_op == OP_LDM);
   assign w_load      = w_xfer && !w_ldm_start;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_OPC;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush)            w_state_nxt = ST_OPC;
      else if (w_ldm_start) w_state_nxt = ST_IMM;
      else if (w_xfer)      w_state_nxt = ST_OPC;
   end

   always_comb begin
      w_alu_en    = 1'b0;
      w_func_ctrl = FUNC_STD;
      w_op_a      = '0;
      w_op_b      = '0;
      w_dest      = '0;
      w_reg_we    = 1'b0;
      w_mem_rd    = 1'b0;
      w_mem_wr    = 1'b0;
      w_illegal   = 1'b0;
      if (r_state == ST_IMM) begin
         w_alu_en = 1'b1;
         w_op_a   = instr;
         w_dest   = r_ldm_rd;
         w_reg_we = 1'b1;
      end else begin
         unique case (w_op)
            OP_NOP: ;
            OP_NOT: begin
               w_alu_en = 1'b1; w_func_ctrl = FUNC_NOT;
               w_op_b = w_rdata_a; w_dest = w_rd; w_reg_we = 1'b1;
            end
            OP_ADD: begin
               w_alu_en = 1'b1; w_func_ctrl = FUNC_ADD;
               w_op_a = w_rdata_a; w_op_b = w_rdata_b; w_dest = w_rd; w_reg_we = 1'b1;
            end
            OP_STD: begin
               w_alu_en = 1'b1; w_op_a = w_rdata_a; w_op_b = w_rdata_b;
               w_dest = w_rd; w_mem_wr = 1'b1;
            end
            OP_LDD: begin
               w_alu_en = 1'b1; w_op_a = w_rdata_a; w_dest = w_rd;
               w_mem_rd = 1'b1; w_reg_we = 1'b1;
            end
            OP_LDM: ;
            default: w_illegal = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ldm_rd <= '0;
      end else if (w_ldm_start && !flush) begin
         r_ldm_rd <= w_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_out_valid <= 1'b0;
         r_alu_en    <= 1'b0;
         r_func_ctrl <= FUNC_STD;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_dest      <= '0;
         r_reg_we    <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_illegal <= w_load && w_illegal;
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_alu_en    <= w_alu_en;
            r_func_ctrl <= w_func_ctrl;
            r_op_a      <= w_op_a;
            r_op_b      <= w_op_b;
            r_dest      <= w_dest;
            r_reg_we    <= w_reg_we;
            r_mem_rd    <= w_mem_rd;
            r_mem_wr    <= w_mem_wr;
         end else if (ex.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign ex.out_valid = r_out_valid;
   assign ex.alu_en    = r_alu_en;
   assign ex.func_ctrl = r_func_ctrl;
   assign ex.op_a      = r_op_a;
   assign ex.op_b      = r_op_b;
   assign ex.dest      = r_dest;
   assign ex.reg_we    = r_reg_we;
   assign ex.mem_rd    = r_mem_rd;
   assign ex.mem_wr    = r_mem_wr;
   assign ex.illegal   = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: inputs change and outputs are sampled on the falling edge.
module tb_decode_stage;
   import pipeline_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, wb_en;
   logic [15:0] instr, wb_data;
   logic [2:0]  wb_addr;
   int          n_pass = 0;
   int          n_total = 0;

   decode_stage_if ex_if ();

   decode_stage dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .instr    (instr),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .ex       (ex_if.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic bundle(input string tag, input logic v, input logic en, input logic [3:0] fn,
                         input logic [15:0] a, input logic [15:0] b, input logic [2:0] d,
                         input logic we, input logic rd, input logic wr);
      chk({tag, ".out_valid"}, 32'(ex_if.out_valid), 32'(v));
      chk({tag, ".alu_en"},    32'(ex_if.alu_en),    32'(en));
      chk({tag, ".func_ctrl"}, 32'(ex_if.func_ctrl), 32'(fn));
      chk({tag, ".op_a"},      32'(ex_if.op_a),      32'(a));
      chk({tag, ".op_b"},      32'(ex_if.op_b),      32'(b));
      chk({tag, ".dest"},      32'(ex_if.dest),      32'(d));
      chk({tag, ".reg_we"},    32'(ex_if.reg_we),    32'(we));
      chk({tag, ".mem_rd"},    32'(ex_if.mem_rd),    32'(rd));
      chk({tag, ".mem_wr"},    32'(ex_if.mem_wr),    32'(wr));
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_if.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      bundle("reset", 0, 0, 4'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0);
      chk("reset.illegal", 32'(ex_if.illegal), 32'h0);
      chk("reset.in_ready", 32'(in_ready), 32'h1);
      rst = 1'b0;

      // Seed R1=0x0005, R2=0xFFFF, then ADD R3,R1,R2
      wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h0005;
      @(negedge clk);
      wb_addr = 3'd2; wb_data = 16'hFFFF;
      @(negedge clk);
      wb_en = 1'b0; in_valid = 1'b1; instr = 16'h1328;
      @(negedge clk);
      bundle("add", 1, 1, 4'b0010, 16'h0005, 16'hFFFF, 3'd3, 1, 0, 0);

      // LDM R4 then immediate 0x1234
      instr = 16'h2C00;
      @(negedge clk);
      chk("ldm1.out_valid", 32'(ex_if.out_valid), 32'h0);
      instr = 16'h1234;
      @(negedge clk);
      bundle("ldm2", 1, 1, 4'b0000, 16'h1234, 16'h0000, 3'd4, 1, 0, 0);

      // R5=0x00A5 then NOT R2,R5 held by back-pressure
      in_valid = 1'b0; wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h00A5;
      @(negedge clk);
      wb_en = 1'b0; in_valid = 1'b1; instr = 16'h0AA0; ex_if.out_ready = 1'b0;
      @(negedge clk);
      instr = 16'h17B4;
      for (int i = 0; i < 3; i++) begin
         bundle($sformatf("hold%0d", i), 1, 1, 4'b0001, 16'h0000, 16'h00A5, 3'd2, 1, 0, 0);
         chk($sformatf("hold%0d.in_ready", i), 32'(in_ready), 32'h0);
         if (i < 2) @(negedge clk);
      end
      ex_if.out_ready = 1'b1;
      #1;
      chk("release.in_ready", 32'(in_ready), 32'h1);
      @(negedge clk);
      bundle("add_r7", 1, 1, 4'b0010, 16'h00A5, 16'h00A5, 3'd7, 1, 0, 0);

      // NOT R6,R1 with R1=0xABCD written back in the same cycle
      wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'hABCD; instr = 16'h0E20;
      @(negedge clk);
      bundle("bypass", 1, 1, 4'b0001, 16'h0000, 16'hABCD, 3'd6, 1, 0, 0);

      // STD R1 -> [R5], then LDD R2,[R5]
      wb_en = 1'b0; instr = 16'h19A0;
      @(negedge clk);
      bundle("std", 1, 1, 4'b0000, 16'h00A5, 16'hABCD, 3'd1, 0, 0, 1);
      instr = 16'h22A0;
      @(negedge clk);
      bundle("ldd", 1, 1, 4'b0000, 16'h00A5, 16'h0000, 3'd2, 1, 1, 0);

      // Flush while waiting for the LDM immediate
      instr = 16'h2C00;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      chk("flush.out_valid", 32'(ex_if.out_valid), 32'h0);
      chk("flush.reg_we", 32'(ex_if.reg_we), 32'h0);
      flush = 1'b0; in_valid = 1'b1; instr = 16'h1000;
      @(negedge clk);
      bundle("post_flush", 1, 1, 4'b0010, 16'h0000, 16'h0000, 3'd0, 1, 0, 0);

      // Undefined opcode 11111
      instr = 16'hF800;
      @(negedge clk);
      chk("illegal.pulse", 32'(ex_if.illegal), 32'h1);
      chk("illegal.out_valid", 32'(ex_if.out_valid), 32'h1);
      chk("illegal.alu_en", 32'(ex_if.alu_en), 32'h0);
      chk("illegal.reg_we", 32'(ex_if.reg_we), 32'h0);
      chk("illegal.mem_rd", 32'(ex_if.mem_rd), 32'h0);
      chk("illegal.mem_wr", 32'(ex_if.mem_wr), 32'h0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("illegal.cleared", 32'(ex_if.illegal), 32'h0);
      chk("idle.out_valid", 32'(ex_if.out_valid), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
